// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile scheduler.
package systolic_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_COMPUTE = 3'd2,
      S_RESULT  = 3'd3,
      S_FINISH  = 3'd4
   } sched_state_e;

   // Default width of the tile count / tile index
   localparam int DEF_TILE_CNT_W = 8;

endpackage : systolic_pkg

// File: rtl/sched_watchdog.sv
// Per-tile COMPUTE watchdog: counts enabled cycles since the last clear and
// flags expiry on the LIMIT-th enabled cycle.
module sched_watchdog #(
   parameter int LIMIT = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;

   // Cycle counter, cleared ahead of each COMPUTE entry
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) cnt_q <= '0;
      else if (en_i)      cnt_q <= cnt_q + 1'b1;
   end

   // Expire during the LIMIT-th COMPUTE cycle so the FSM leaves on that edge
   assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule : sched_watchdog

// File: rtl/systolic_tile_scheduler.sv
// Job-level controller for the systolic array: issues one start per tile,
// waits for the rising edge of the array done flag, then hands a per-tile
// result token to the drain logic.
// Optional feature: define SYSTOLIC_SCHED_TIMEOUT_EN to build the COMPUTE
// watchdog (error_o + early FINISH after TIMEOUT_CYCLES).
module systolic_tile_scheduler
   import systolic_pkg::*;
#(
   parameter int N              = 8,
   parameter int TILE_CNT_W     = DEF_TILE_CNT_W,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  job_valid_i,
   output logic                  job_ready_o,
   input  logic [TILE_CNT_W-1:0] job_tiles_i,
   output logic                  array_start_o,
   input  logic                  array_done_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [TILE_CNT_W-1:0] result_tile_o,
   output logic                  busy_o,
   output logic                  job_done_o,
   output logic                  error_o
);

   // Elaboration-time sanity checks on the configuration
   if (TILE_CNT_W < $clog2(N)) begin : g_chk_idx_w
      $error("TILE_CNT_W too narrow for array dimension N");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   sched_state_e          state_q;
   logic [TILE_CNT_W-1:0] tiles_q;
   logic [TILE_CNT_W-1:0] idx_q;
   logic                  ready_q;
   logic                  start_q;
   logic                  rvalid_q;
   logic                  jdone_q;
   logic                  done_q;
   logic                  done_rise;
   logic                  wd_expire;

   // Registered copy of the level done flag for rising-edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) done_q <= 1'b0;
      else       done_q <= array_done_i;
   end

   // A flag already high when COMPUTE is entered never produces a rise
   assign done_rise = array_done_i & ~done_q;

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
   logic err_q;

   sched_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (state_q == S_ISSUE),
      .en_i     (state_q == S_COMPUTE),
      .expire_o (wd_expire)
   );

   assign error_o = err_q;
`else
   assign wd_expire = 1'b0;
   assign error_o   = 1'b0;
`endif

   // Scheduler FSM; outputs are registered and set on the transition edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         tiles_q  <= '0;
         idx_q    <= '0;
         ready_q  <= 1'b0;
         start_q  <= 1'b0;
         rvalid_q <= 1'b0;
         jdone_q  <= 1'b0;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
         err_q    <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         jdone_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (job_valid_i && ready_q) begin
                  ready_q <= 1'b0;
                  tiles_q <= job_tiles_i;
                  idx_q   <= '0;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
                  err_q   <= 1'b0;
`endif
                  if (job_tiles_i == '0) begin
                     state_q <= S_FINISH;
                     jdone_q <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                     start_q <= 1'b1;
                  end
               end
            end
            S_ISSUE: state_q <= S_COMPUTE;
            S_COMPUTE: begin
               if (done_rise) begin
                  state_q  <= S_RESULT;
                  rvalid_q <= 1'b1;
               end else if (wd_expire) begin
                  // Abandon the job; no result token for the hung tile
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
                  err_q   <= 1'b1;
`endif
                  state_q <= S_FINISH;
                  jdone_q <= 1'b1;
               end
            end
            S_RESULT: begin
               if (result_ready_i) begin
                  rvalid_q <= 1'b0;
                  if (idx_q == TILE_CNT_W'(tiles_q - 1'b1)) begin
                     state_q <= S_FINISH;
                     jdone_q <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_ISSUE;
                     start_q <= 1'b1;
                  end
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign job_ready_o    = ready_q;
   assign array_start_o  = start_q;
   assign result_valid_o = rvalid_q;
   assign result_tile_o  = idx_q;
   assign job_done_o     = jdone_q;
   assign busy_o         = (state_q != S_IDLE);

endmodule : systolic_tile_scheduler

// File: tb/tb_systolic_tile_scheduler.sv
// Directed self-checking bench for systolic_tile_scheduler.
module tb_systolic_tile_scheduler;

   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          job_valid;
   logic          job_ready;
   logic [TW-1:0] job_tiles;
   logic          array_start;
   logic          array_done;
   logic          result_valid;
   logic          result_ready;
   logic [TW-1:0] result_tile;
   logic          busy;
   logic          job_done;
   logic          error;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   systolic_tile_scheduler #(
      .N              (8),
      .TILE_CNT_W     (TW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .job_valid_i    (job_valid),
      .job_ready_o    (job_ready),
      .job_tiles_i    (job_tiles),
      .array_start_o  (array_start),
      .array_done_i   (array_done),
      .result_valid_o (result_valid),
      .result_ready_i (result_ready),
      .result_tile_o  (result_tile),
      .busy_o         (busy),
      .job_done_o     (job_done),
      .error_o        (error)
   );

   // Advance one clock and sample just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; job_valid = 1'b0; job_tiles = '0;
      array_done = 1'b0; result_ready = 1'b0;
      step(); step();
      n_tests++;
      if ({job_ready, array_start, result_valid, busy, job_done, error} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b want=000000",
                  {job_ready, array_start, result_valid, busy, job_done, error});
      end
      rst = 1'b0;
      step();
      n_tests++;
      if ({job_ready, array_start, result_valid, busy, job_done, error} !== 6'b100000) begin
         n_fail++;
         $display("FAIL idle_outputs got=%b want=100000",
                  {job_ready, array_start, result_valid, busy, job_done, error});
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (array_start !== 1'b0 || job_ready !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL idle_no_start bad_cycles=%0d want=0", bad);
      end
   endtask

   // Three tiles, done rises 10 cycles after each start, drain always ready
   task automatic test_multi_tile();
      int starts, nres, ndone, cd, badtile;
      bit fin;
      starts = 0; nres = 0; ndone = 0; cd = 0; badtile = 0; fin = 0;
      result_ready = 1'b1;
      job_valid = 1'b1; job_tiles = 8'd3;
      for (int c = 0; c < 300 && !fin; c++) begin
         step();
         job_valid = 1'b0;
         if (array_start === 1'b1) begin
            starts++; cd = 10; array_done = 1'b0;
         end else if (cd > 0) begin
            cd--;
            array_done = (cd == 0);
         end else begin
            array_done = 1'b0;
         end
         if (result_valid === 1'b1) begin
            if (result_tile !== TW'(nres)) badtile++;
            nres++;
         end
         if (job_done === 1'b1) begin
            ndone++; fin = 1;
         end
      end
      array_done = 1'b0;
      n_tests++;
      if (!fin) begin n_fail++; $display("FAIL multi_timeout job_done never seen"); end
      n_tests++;
      if (starts != 3) begin n_fail++; $display("FAIL multi_starts got=%0d want=3", starts); end
      n_tests++;
      if (nres != 3 || badtile != 0) begin
         n_fail++;
         $display("FAIL multi_results got=%0d bad_order=%0d want=3/0", nres, badtile);
      end
      step();
      n_tests++;
      if (job_done !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_end done=%b ready=%b busy=%b want=0/1/0", job_done, job_ready, busy);
      end
   endtask

   task automatic test_zero_tiles();
      job_valid = 1'b1; job_tiles = 8'd0;
      step();
      job_valid = 1'b0;
      n_tests++;
      if (job_done !== 1'b1 || array_start !== 1'b0 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_done done=%b start=%b rvalid=%b want=1/0/0",
                  job_done, array_start, result_valid);
      end
      step();
      n_tests++;
      if (job_done !== 1'b0 || job_ready !== 1'b1 || array_start !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_after done=%b ready=%b start=%b want=0/1/0",
                  job_done, job_ready, array_start);
      end
      step();
   endtask

   task automatic test_done_held();
      int bad;
      bad = 0;
      result_ready = 1'b1;
      job_valid = 1'b1; job_tiles = 8'd2;
      step();
      job_valid = 1'b0;
      n_tests++;
      if (array_start !== 1'b1 || job_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL held_first_start start=%b ready=%b busy=%b want=1/0/1",
                  array_start, job_ready, busy);
      end
      step(); step(); step();
      array_done = 1'b1;
      step();
      n_tests++;
      if (result_valid !== 1'b1 || result_tile !== 8'd0) begin
         n_fail++;
         $display("FAIL held_tile0 rvalid=%b tile=%0d want=1/0", result_valid, result_tile);
      end
      step();
      n_tests++;
      if (array_start !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL held_second_start start=%b rvalid=%b want=1/0", array_start, result_valid);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         if (result_valid !== 1'b0) bad++;
      end
      array_done = 1'b0;
      step();
      if (result_valid !== 1'b0) bad++;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL held_no_complete early_results=%0d want=0", bad);
      end
      array_done = 1'b1;
      step();
      n_tests++;
      if (result_valid !== 1'b1 || result_tile !== 8'd1) begin
         n_fail++;
         $display("FAIL held_reraise rvalid=%b tile=%0d want=1/1", result_valid, result_tile);
      end
      array_done = 1'b0;
      step();
      n_tests++;
      if (job_done !== 1'b1) begin
         n_fail++;
         $display("FAIL held_job_done got=%b want=1", job_done);
      end
      step();
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      result_ready = 1'b0;
      job_valid = 1'b1; job_tiles = 8'd2;
      step();
      job_valid = 1'b0;
      step();
      array_done = 1'b1;
      step();
      array_done = 1'b0;
      n_tests++;
      if (result_valid !== 1'b1 || result_tile !== 8'd0) begin
         n_fail++;
         $display("FAIL bp_first rvalid=%b tile=%0d want=1/0", result_valid, result_tile);
      end
      for (int i = 0; i < 7; i++) begin
         step();
         if (result_valid !== 1'b1 || result_tile !== 8'd0 || array_start !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold unstable_cycles=%0d want=0", bad);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      n_tests++;
      if (array_start !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_next_start start=%b rvalid=%b want=1/0", array_start, result_valid);
      end
      step();
      array_done = 1'b1;
      step();
      array_done = 1'b0;
      n_tests++;
      if (result_valid !== 1'b1 || result_tile !== 8'd1) begin
         n_fail++;
         $display("FAIL bp_second rvalid=%b tile=%0d want=1/1", result_valid, result_tile);
      end
      result_ready = 1'b1;
      step();
      n_tests++;
      if (job_done !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_job_done done=%b rvalid=%b want=1/0", job_done, result_valid);
      end
      step();
      n_tests++;
      if (job_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_back got=%b want=1", job_ready);
      end
   endtask

   task automatic test_reset_mid_job();
      array_done = 1'b0;
      job_valid = 1'b1; job_tiles = 8'd1;
      step();
      job_valid = 1'b0;
      step(); step(); step();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_precheck busy=%b want=1", busy);
      end
      rst = 1'b1;
      step();
      n_tests++;
      if (busy !== 1'b0 || job_ready !== 1'b0 || job_done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_idle busy=%b ready=%b done=%b err=%b want=0/0/0/0",
                  busy, job_ready, job_done, error);
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || array_start !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_after ready=%b busy=%b start=%b want=1/0/0",
                  job_ready, busy, array_start);
      end
   endtask

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      bad = 0;
      array_done = 1'b0;
      job_valid = 1'b1; job_tiles = 8'd1;
      step();
      job_valid = 1'b0;
      step();
      for (int i = 0; i < 15; i++) begin
         step();
         if (job_done !== 1'b0 || error !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL timeout_early bad_cycles=%0d want=0", bad);
      end
      step();
      n_tests++;
      if (job_done !== 1'b1 || error !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_fire done=%b err=%b rvalid=%b want=1/1/0",
                  job_done, error, result_valid);
      end
      step();
      n_tests++;
      if (error !== 1'b1 || job_ready !== 1'b1 || job_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_sticky err=%b ready=%b done=%b want=1/1/0",
                  error, job_ready, job_done);
      end
      job_valid = 1'b1; job_tiles = 8'd0;
      step();
      job_valid = 1'b0;
      n_tests++;
      if (error !== 1'b0 || job_done !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_clear err=%b done=%b want=0/1", error, job_done);
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_multi_tile();
      test_zero_tiles();
      test_done_held();
      test_backpressure();
      test_reset_mid_job();
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_systolic_tile_scheduler

// File: doc/systolic_tile_scheduler.md
# systolic_tile_scheduler

Job-level controller for the systolic array: accepts a multiply job of one or more tiles over a valid/ready handshake. For each tile it issues a single-cycle start to the array and waits for the array's completion flag. It then presents a per-tile result token to the downstream drain logic and holds it until that logic accepts. It sits between the host/command interface and the array top level, and is the only driver of the array start input.

## Interface
Parameters:
- `N`, 8: array dimension; informational, used for the tile index width check only.
- `TILE_CNT_W`, 8: width of the tile count and tile index.
- `TIMEOUT_CYCLES`, 4096: maximum COMPUTE cycles per tile. Only used with the timeout feature.

Ports:
- `clk_i`, in, 1: single clock; all logic is rising-edge.
- `rst_i`, in, 1: reset; synchronous, active-high.
- `job_valid_i`, in, 1: job request.
- `job_ready_o`, out, 1: scheduler can accept a job.
- `job_tiles_i`, in, TILE_CNT_W: number of tiles in the job, unsigned.
- `array_start_o`, out, 1: start pulse to the array.
- `array_done_i`, in, 1: array completion flag; level, may stay high across tiles.
- `result_valid_o`, out, 1: tile result available.
- `result_ready_i`, in, 1: drain logic accepts the result.
- `result_tile_o`, out, TILE_CNT_W: index of the completed tile.
- `busy_o`, out, 1: high in every state except IDLE.
- `job_done_o`, out, 1: one-cycle pulse at job end.
- `error_o`, out, 1: timeout flag for the last job.

## Operation
- FSM states: IDLE, ISSUE, COMPUTE, RESULT, FINISH.
- IDLE:
  - `job_ready_o`=1.
  - On `job_valid_i & job_ready_o`: latch `job_tiles_i`, clear the tile index and `error_o`.
  - If tiles==0, go to FINISH; else go to ISSUE.
- ISSUE: `array_start_o`=1 for exactly this cycle, then go to COMPUTE.
- COMPUTE:
  - Completion is detected on the rising edge of the level flag: `done_rise = array_done_i & ~done_q`. `done_q` is a register of `array_done_i` and resets to 0.
  - A flag already high on entry to COMPUTE does not complete the tile.
  - On `done_rise`, go to RESULT.
- RESULT:
  - `result_valid_o`=1 and `result_tile_o`=current index; both stay stable until `result_ready_i`.
  - On handshake with index==tiles-1, go to FINISH.
  - Otherwise increment the index and go to ISSUE.
- FINISH: `job_done_o`=1 for one cycle, then go to IDLE.
- `job_valid_i` is ignored outside IDLE. No job queueing; the requester must hold valid.
- Index arithmetic is unsigned modulo 2^TILE_CNT_W. The max job is 2^TILE_CNT_W−1 tiles; the last index is tiles−1 and never wraps.
- Reset mid-job: the FSM returns to IDLE on the next edge. Nothing is replayed. Partially completed tiles are dropped.
- Reset values: `job_ready_o`=0 during the reset cycle and 1 after. All other outputs are 0.

## Timing
- Job accept edge k: `array_start_o` is high in cycle k+1, and the FSM is in COMPUTE from k+2.
- `done_rise` sampled at edge m: `result_valid_o` is high from cycle m+1.
- Result handshake at edge r: `array_start_o` for the next tile is high in cycle r+1. For the last tile, `job_done_o` is high in cycle r+1.
- Minimum per-tile overhead: 3 cycles, plus array latency.
- Zero-tile job: `job_done_o` one cycle after accept. No start is issued.
- `job_ready_o` returns high in the cycle after FINISH.

## Configuration
- `SYSTOLIC_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in COMPUTE and is cleared on entry to COMPUTE.
  - If it reaches `TIMEOUT_CYCLES` without `done_rise`, `error_o` is set and the FSM goes to FINISH, which pulses `job_done_o`. No result is issued for that tile.
  - `error_o` stays set until the next job accept or reset.
- Undefined: COMPUTE waits indefinitely, `error_o` is tied 0, and no counter is built.

## Structure
- Shared package `systolic_pkg` holds:
  - the `sched_state_e` enum (IDLE, ISSUE, COMPUTE, RESULT, FINISH);
  - the default `TILE_CNT_W` localparam.
- One sub-module, `sched_watchdog`: counter, clear, and expire output, instantiated only under the macro.
- The edge detector and FSM stay in the top module.

## Test plan
- Reset, then idle: all outputs 0 except `job_ready_o`=1. `array_start_o` never asserts.
- Job with tiles=3 and done rising 10 cycles after each start, `result_ready_i` tied 1:
  - exactly 3 start pulses;
  - `result_tile_o` = 0, 1, 2, in order;
  - one `job_done_o`.
- Job with tiles=0: `job_done_o` one cycle after accept. No start, no result.
- `array_done_i` held high from the previous tile through ISSUE, then dropped and re-raised after 5 cycles: the tile completes only on the re-raise.
- Backpressure: tiles=2 with `result_ready_i` low for 7 cycles. `result_valid_o` and `result_tile_o`=0 are held stable, and the second start comes one cycle after the handshake.
- With `SYSTOLIC_SCHED_TIMEOUT_EN` and TIMEOUT_CYCLES=16, done never asserts:
  - `error_o`=1 and `job_done_o` pulse 16 cycles into COMPUTE;
  - `rst_i` mid-COMPUTE in a separate run returns the FSM to IDLE next edge.
